// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants for the branch/hazard control path.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    BR_EVAL    = 2'd2,
    REDIRECT   = 2'd3
  } state_e;

  localparam logic PC_SEL_SEQ = 1'b0;
  localparam logic PC_SEL_BR  = 1'b1;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_LINK = 5'd31;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use compare: a load in EX writing a register that ID reads.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic                i_ex_mem_read,
  input  logic [REG_BITS-1:0] i_ex_rd,
  input  logic [REG_BITS-1:0] i_id_rs,
  input  logic [REG_BITS-1:0] i_id_rt,
  output logic                o_hazard
);

  logic w_rd_nonzero;
  logic w_rd_match;

  // r0 is hard-wired, so a load targeting it never creates a dependency
  assign w_rd_nonzero = (i_ex_rd != REG_BITS'(REG_ZERO));
  assign w_rd_match   = (i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt);
  assign o_hazard     = i_ex_mem_read && w_rd_nonzero && w_rd_match;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Branch sequencing FSM: load-use stalls, branch evaluation in EX, redirect/squash.
// Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot instruction on a taken branch.
module branch_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int REG_BITS     = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_branch,
  input  logic                id_link,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic                ex_mem_read,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ch_taken,
  output logic                pc_we,
  output logic                pc_sel,
  output logic                if_id_we,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic                link_we,
  output logic                busy
);

  localparam int CNT_W = $clog2(STALL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_link;
  logic             w_link_nxt;
  logic             w_hazard;
  logic             w_run_decode;

  logic w_pc_we, w_pc_sel, w_if_id_we, w_if_id_flush, w_id_ex_bubble, w_link_we;

  load_use_detect #(
    .REG_BITS (REG_BITS)
  ) u_load_use_detect (
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rd       (ex_rd),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .o_hazard      (w_hazard)
  );

  always_comb begin
    w_pc_we        = 1'b1;
    w_pc_sel       = PC_SEL_SEQ;
    w_if_id_we     = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_bubble = 1'b0;
    w_link_we      = 1'b0;
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_link_nxt     = r_link;
    w_run_decode   = 1'b0;

    case (r_state)
      RUN: w_run_decode = 1'b1;
      LOAD_STALL: begin
        if (r_cnt != '0) begin
          w_pc_we        = 1'b0;
          w_if_id_we     = 1'b0;
          w_id_ex_bubble = 1'b1;
          w_cnt_nxt      = r_cnt - CNT_W'(1);
        end else begin
          w_link_nxt  = id_link;
          w_state_nxt = BR_EVAL;
        end
      end
      BR_EVAL: begin
        w_link_we = r_link;
        if (ch_taken) begin
          w_pc_sel      = PC_SEL_BR;
          w_if_id_flush = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
          w_id_ex_bubble = 1'b0;
`else
          w_id_ex_bubble = 1'b1;
`endif
          w_state_nxt = REDIRECT;
        end else begin
          w_run_decode = 1'b1;
        end
      end
      REDIRECT: w_state_nxt = RUN;
    endcase

    // A not-taken BR_EVAL hands the next ID instruction straight to RUN decode
    if (w_run_decode) begin
      w_state_nxt = RUN;
      if (id_branch && w_hazard) begin
        w_pc_we        = 1'b0;
        w_if_id_we     = 1'b0;
        w_id_ex_bubble = 1'b1;
        w_cnt_nxt      = CNT_LOAD;
        w_state_nxt    = LOAD_STALL;
      end else if (id_branch) begin
        w_link_nxt  = id_link;
        w_state_nxt = BR_EVAL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_link  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_link  <= w_link_nxt;
    end
  end

  // Every output, including the enables, is held low while reset is asserted
  assign pc_we        = rst_n & w_pc_we;
  assign pc_sel       = rst_n & w_pc_sel;
  assign if_id_we     = rst_n & w_if_id_we;
  assign if_id_flush  = rst_n & w_if_id_flush;
  assign id_ex_bubble = rst_n & w_id_ex_bubble;
  assign link_we      = rst_n & w_link_we;
  assign busy         = rst_n & (r_state != RUN);

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Self-checking bench for branch_hazard_ctrl: directed table, reset corner, random vs model.
module tb_branch_hazard_ctrl;

  localparam int STALL = 2;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam logic TB_BUB = 1'b0;
`else
  localparam logic TB_BUB = 1'b1;
`endif

  logic       clk, rst_n;
  logic       id_branch, id_link, ex_mem_read, ch_taken;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, link_we, busy;

  int checks   = 0;
  int failures = 0;

  branch_hazard_ctrl #(
    .STALL_CYCLES (STALL),
    .REG_BITS     (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_branch    (id_branch),
    .id_link      (id_link),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ch_taken     (ch_taken),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .if_id_we     (if_id_we),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .link_we      (link_we),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, link_we, busy}
  typedef struct {
    logic       br, lk;
    logic [4:0] rs, rt;
    logic       mr;
    logic [4:0] rd;
    logic       tk;
    logic [6:0] exp;
  } vec_t;

  localparam logic [6:0] D  = 7'b1010000;
  localparam logic [6:0] DB = 7'b1010001;
  localparam logic [6:0] S  = 7'b0000100;
  localparam logic [6:0] SB = 7'b0000101;
  localparam logic [6:0] L  = 7'b0000010;
  localparam logic [6:0] TK = {4'b1111, TB_BUB, 2'b01};

  function automatic vec_t mk(logic br, logic lk, logic [4:0] rs, logic [4:0] rt,
                              logic mr, logic [4:0] rd, logic tk, logic [6:0] exp);
    vec_t v;
    v.br = br; v.lk = lk; v.rs = rs; v.rt = rt;
    v.mr = mr; v.rd = rd; v.tk = tk; v.exp = exp;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, link_we, busy};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b (pc_we,pc_sel,if_id_we,flush,bubble,link_we,busy)",
               name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic lk, input logic [4:0] rs, input logic [4:0] rt,
                       input logic mr, input logic [4:0] rd, input logic tk);
    id_branch = br; id_link = lk; id_rs = rs; id_rt = rt;
    ex_mem_read = mr; ex_rd = rd; ch_taken = tk;
  endtask

  // Reference model: pending-work bookkeeping rather than a state encoding
  bit m_stalling, m_eval, m_link, m_redir;
  int m_left;

  task automatic model_reset();
    m_stalling = 0; m_eval = 0; m_link = 0; m_redir = 0; m_left = 0;
  endtask

  task automatic model_step(output logic [6:0] exp);
    bit hz, pw, ps, iw, fl, bb, lw, bz, run_like;
    bit n_stalling, n_eval, n_link, n_redir;
    int n_left;
    hz = ex_mem_read && (ex_rd != 0) && (ex_rd == id_rs || ex_rd == id_rt);
    pw = 1; ps = 0; iw = 1; fl = 0; bb = 0; lw = 0;
    bz = m_redir || m_stalling || m_eval;
    run_like = 0;
    n_stalling = m_stalling; n_eval = m_eval; n_link = m_link; n_redir = m_redir; n_left = m_left;
    if (m_redir) begin
      n_redir = 0;
    end else if (m_stalling) begin
      if (m_left > 0) begin
        pw = 0; iw = 0; bb = 1; n_left = m_left - 1;
      end else begin
        n_stalling = 0; n_eval = 1; n_link = id_link;
      end
    end else begin
      if (m_eval) begin
        lw = m_link; n_eval = 0;
        if (ch_taken) begin
          ps = 1; fl = 1; bb = TB_BUB; n_redir = 1;
        end else run_like = 1;
      end else run_like = 1;
      if (run_like) begin
        if (id_branch && hz) begin
          pw = 0; iw = 0; bb = 1; n_stalling = 1; n_left = STALL - 1;
        end else if (id_branch) begin
          n_eval = 1; n_link = id_link;
        end
      end
    end
    exp = {pw, ps, iw, fl, bb, lw, bz};
    m_stalling = n_stalling; m_eval = n_eval; m_link = n_link; m_redir = n_redir; m_left = n_left;
  endtask

  vec_t vecs[$];
  logic [6:0] exp_r;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, D));
    vecs.push_back(mk(1, 0, 3, 4, 0, 0, 0, D));       // not-taken branch enters
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, DB));      // BR_EVAL not taken
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, D));
    vecs.push_back(mk(1, 0, 3, 4, 0, 0, 0, D));       // taken branch enters
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, TK));
    vecs.push_back(mk(1, 0, 3, 4, 0, 0, 0, DB));      // REDIRECT ignores id_branch
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, D));
    vecs.push_back(mk(1, 0, 8, 0, 1, 8, 0, S));       // load-use on rs
    vecs.push_back(mk(1, 0, 8, 0, 1, 8, 0, SB));
    vecs.push_back(mk(1, 1, 8, 0, 1, 8, 0, DB));      // release, capture link
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, DB | L));  // link not taken
    vecs.push_back(mk(1, 1, 8, 0, 1, 0, 0, D));       // ex_rd=0: no stall
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, TK | L));  // link taken
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, DB));
    vecs.push_back(mk(1, 0, 5, 6, 0, 0, 0, D));
    vecs.push_back(mk(1, 0, 1, 2, 0, 0, 0, DB));      // back-to-back, no hazard
    vecs.push_back(mk(1, 0, 3, 9, 1, 9, 0, SB));      // back-to-back into stall on rt
    vecs.push_back(mk(1, 0, 3, 9, 1, 9, 0, SB));
    vecs.push_back(mk(1, 0, 3, 9, 1, 9, 0, DB));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, DB));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, D));

    #1;
    check("reset_outputs", outs(), 7'b0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].br, vecs[i].lk, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].rd, vecs[i].tk);
      #1;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset while stalled with counter=1
    @(negedge clk);
    drive(1, 1, 8, 0, 1, 8, 0);
    #1;
    check("rst_mid_enter", outs(), S);
    @(negedge clk);
    #1;
    check("rst_mid_stall", outs(), SB);
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", outs(), 7'b0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    check("rst_mid_release", outs(), D);
    @(negedge clk);
    drive(1, 0, 1, 2, 0, 0, 0);
    #1;
    check("post_rst_branch", outs(), D);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("post_rst_eval_nolink", outs(), DB);

    // Randomized run against the model; DUT is back in RUN after the idle cycle above
    @(negedge clk);
    #1;
    check("pre_random_idle", outs(), D);
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      rst_n = ($urandom_range(0, 63) != 0);
      #1;
      if (!rst_n) begin
        exp_r = 7'b0;
        model_reset();
      end else begin
        model_step(exp_r);
      end
      check($sformatf("rand%0d", n), outs(), exp_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_hazard_ctrl.md
Name: branch_hazard_ctrl

Overview:
- Pipeline control FSM that sequences conditional branches through the condition handler and the IF/ID/EX registers.
- Detects load-use hazards on branch source registers and stalls for them.
- Samples the condition handler's taken bit when the branch sits in EX, then redirects the PC and squashes wrong-path instructions.
- Sits beside the hazard unit; drives the PC mux and enables, IF/ID flush and ID/EX bubble.

Parameters:
- STALL_CYCLES, 1, load-use stall length in cycles (1..7).
- REG_BITS, 5, register-specifier width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- id_branch  in  1  ID holds a conditional branch (BEQ/BNE/BGTZ/BLEZ/REGIMM)
- id_link  in  1  ID branch is a link variant (BGEZAL/BLTZAL/BAL)
- id_rs  in  REG_BITS  branch source rs
- id_rt  in  REG_BITS  branch source rt (0 when unused)
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_BITS  destination of the EX instruction
- ch_taken  in  1  condition handler output; valid only in state BR_EVAL
- pc_we  out  1  PC write enable
- pc_sel  out  1  0 = PC+4, 1 = branch target
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  clear IF/ID to NOP at next edge
- id_ex_bubble  out  1  load NOP into ID/EX at next edge
- link_we  out  1  write PC+8 into r31 this cycle
- busy  out  1  FSM not in RUN

Behaviour:
- Reset: rst_n low asynchronously forces state RUN, stall counter 0 and the link register 0. While rst_n is low, all outputs are 0, including pc_we and if_id_we.
- Outputs are combinational from state, counter and inputs (Mealy in RUN/BR_EVAL). No registered outputs.
- hazard = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt).
- Default output decode: pc_we=1, if_id_we=1, pc_sel=0, if_id_flush=0, id_ex_bubble=0, link_we=0.
- RUN:
  - id_branch && hazard: pc_we=0, if_id_we=0, id_ex_bubble=1; counter <= STALL_CYCLES-1; next LOAD_STALL.
  - id_branch && !hazard: capture id_link; next BR_EVAL.
  - Otherwise stay in RUN.
- LOAD_STALL:
  - pc_we=0, if_id_we=0, id_ex_bubble=1.
  - counter != 0: decrement and stay.
  - counter == 0: release the stall (defaults apply), capture id_link, next BR_EVAL.
  - With STALL_CYCLES=1, exactly one bubble is inserted.
- BR_EVAL (branch in EX, ch_taken valid):
  - link_we = captured link bit, asserted regardless of ch_taken.
  - ch_taken=1: pc_sel=1, pc_we=1, if_id_flush=1, id_ex_bubble=1; next REDIRECT.
  - ch_taken=0: behave exactly as RUN for the instruction now in ID, so back-to-back branches go directly to LOAD_STALL or BR_EVAL with no lost cycle.
- REDIRECT:
  - One cycle; defaults apply (target instruction being fetched, ID holds a NOP).
  - id_branch ignored; next RUN.
- Wrong-path cost: taken branch squashes 2 instructions (1 with DELAY_SLOT_EN); not-taken costs 0.
- Stall counter width is $clog2(STALL_CYCLES+1). The counter never wraps; the decrement happens only when nonzero.
- Reset mid-operation (any state) returns to RUN. No pending redirect or link survives reset.
- busy = (state != RUN).

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined: MIPS architectural delay slot. On a taken BR_EVAL, id_ex_bubble=0, so the instruction after the branch completes; if_id_flush=1 still squashes the fetched instruction.
- Undefined: both wrong-path instructions are squashed as described in Behaviour.
- Link semantics are unchanged in both cases.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state typedef (RUN=2'd0, LOAD_STALL=2'd1, BR_EVAL=2'd2, REDIRECT=2'd3);
  - PC_SEL_SEQ=1'b0 and PC_SEL_BR=1'b1;
  - REG_ZERO=5'd0 and the link register index 5'd31.
- One natural sub-module, load_use_detect, holds the combinational hazard compare so the general hazard unit can reuse it.
- The FSM, counter and output decode stay in branch_hazard_ctrl.

Test Plan:
- Not-taken branch: id_branch=1, no hazard → BR_EVAL next cycle; ch_taken=0 → pc_sel=0, no flush, no bubble; back in RUN with zero stall cycles.
- Taken branch: id_branch=1; BR_EVAL with ch_taken=1 → pc_sel=1, if_id_flush=1, id_ex_bubble=1 (0 with BRANCH_DELAY_SLOT_EN); REDIRECT for 1 cycle, then RUN.
- Load-use stall: ex_mem_read=1, ex_rd=8, id_rs=8, STALL_CYCLES=2 → pc_we=if_id_we=0 and id_ex_bubble=1 for exactly 2 cycles, then BR_EVAL. Repeat with ex_rd=0 → no stall.
- Link branch: id_link=1, BR_EVAL with ch_taken=0 → link_we=1 for exactly one cycle and pc_sel=0; with ch_taken=1 → link_we=1 and pc_sel=1.
- Back-to-back branches: BR_EVAL not-taken while id_branch=1 and no hazard → stays in BR_EVAL, with no REDIRECT or RUN cycle between the two branches.
- Reset mid-operation: drop rst_n while in LOAD_STALL with counter=1 → all outputs 0 immediately; after release, state RUN, pc_we=1, busy=0.
